// File: rtl/logip_pkg.sv
// ---------------------------------------------------------------------------
// logip_pkg
//   Shared constants and types for the logic-analyser readout path.
//   GROUP_W     : width of one sample group (one byte on the UART).
//   ser_state_t : sample_serializer FSM states.
// ---------------------------------------------------------------------------
package logip_pkg;

    localparam int GROUP_W = 8;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_SEND,
        SER_DONE
    } ser_state_t;

endpackage

// File: rtl/lowest_set_enc.sv
// ---------------------------------------------------------------------------
// lowest_set_enc
//   Purely combinational lowest-set-bit encoder.
//   Ports:
//     v      in  W      input mask
//     idx    out IDX_W  index of lowest set bit (0 when v == 0)
//     onehot out W      one-hot of lowest set bit (0 when v == 0)
//     last   out 1      exactly one bit of v is set
//     any    out 1      at least one bit of v is set
// ---------------------------------------------------------------------------
module lowest_set_enc #(
    parameter int W     = 4,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     v,
    output logic [IDX_W-1:0] idx,
    output logic [W-1:0]     onehot,
    output logic             last,
    output logic             any
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot = v & (~v + W'(1));
    assign any    = |v;
    assign last   = any && ((v & ~onehot) == '0);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/sample_serializer.sv
// ---------------------------------------------------------------------------
// sample_serializer
//   Takes one packed sample word from sample memory and emits its enabled
//   byte groups, group 0 first, to the UART transmitter. Groups whose
//   cfg bit is set are skipped.
//   Ports:
//     clk_i      in  1         clock, rising edge
//     rst_i      in  1         synchronous active-high reset
//     cfg_stb_i  in  1         latch cfg_i
//     cfg_i      in  INPUT     group-disable flags (1 = skip group)
//     stb_i      in  1         sample word valid (taken when rdy_o)
//     d_i        in  8*INPUT   packed sample word
//     rdy_o      out 1         can accept a word
//     tx_stb_o   out 1         byte valid toward UART tx
//     tx_byte_o  out 8         byte payload (registered)
//     tx_rdy_i   in  1         UART tx accepts the byte
//     done_o     out 1         word fully emitted (or fully disabled)
// ---------------------------------------------------------------------------
module sample_serializer
    import logip_pkg::*;
#(
    parameter int INPUT = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cfg_stb_i,
    input  logic [INPUT-1:0]         cfg_i,
    input  logic                     stb_i,
    input  logic [GROUP_W*INPUT-1:0] d_i,
    output logic                     rdy_o,
    output logic                     tx_stb_o,
    output logic [GROUP_W-1:0]       tx_byte_o,
    input  logic                     tx_rdy_i,
    output logic                     done_o
);

    localparam int IDX_W = (INPUT > 1) ? $clog2(INPUT) : 1;

    ser_state_t                 state, state_nxt;
    logic [INPUT-1:0]           cfg_q;
    logic [INPUT-1:0]           pending_q;
    logic [GROUP_W*INPUT-1:0]   word_q;

    logic                       accept, xfer, load_empty;
    logic [INPUT-1:0]           after_clr, enc_in;
    logic [GROUP_W*INPUT-1:0]   word_src;
    logic [GROUP_W-1:0]         byte_sel;

    logic [IDX_W-1:0]           cur_idx, nxt_idx;
    logic [INPUT-1:0]           cur_oh, nxt_oh;
    logic                       cur_last, cur_any, nxt_last, nxt_any;

    assign accept     = stb_i && (state != SER_SEND);
    assign xfer       = (state == SER_SEND) && tx_rdy_i;
    // Word snapshots the enable mask that was in place before this edge.
    assign load_empty = &cfg_q;

    // Group currently presented.
    lowest_set_enc #(.W(INPUT)) u_cur (
        .v      (pending_q),
        .idx    (cur_idx),
        .onehot (cur_oh),
        .last   (cur_last),
        .any    (cur_any)
    );

    assign after_clr = pending_q & ~cur_oh;

    // Group to present next: first group of a new word, or the one after
    // the group being transferred now.
    assign enc_in   = accept ? ~cfg_q : after_clr;
    assign word_src = accept ? d_i : word_q;

    lowest_set_enc #(.W(INPUT)) u_nxt (
        .v      (enc_in),
        .idx    (nxt_idx),
        .onehot (nxt_oh),
        .last   (nxt_last),
        .any    (nxt_any)
    );

    assign byte_sel = word_src[nxt_idx*GROUP_W +: GROUP_W];

    logic unused_enc;
    assign unused_enc = ^{cur_idx, nxt_oh, nxt_last};

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= SER_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rdy_o     = 1'b0;
        tx_stb_o  = 1'b0;
        done_o    = 1'b0;
        case (state)
            SER_IDLE: begin
                rdy_o = 1'b1;
                if (stb_i) state_nxt = load_empty ? SER_DONE : SER_SEND;
            end
            SER_SEND: begin
                tx_stb_o = 1'b1;
                // !cur_any cannot happen in normal flow; bail out rather than hang.
                if (!cur_any || (tx_rdy_i && cur_last)) state_nxt = SER_DONE;
            end
            SER_DONE: begin
                rdy_o  = 1'b1;
                done_o = 1'b1;
                if (stb_i) state_nxt = load_empty ? SER_DONE : SER_SEND;
                else       state_nxt = SER_IDLE;
            end
            default: state_nxt = SER_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_q     <= '0;
            pending_q <= '0;
            word_q    <= '0;
            tx_byte_o <= '0;
        end else begin
            if (cfg_stb_i) cfg_q <= cfg_i;
            if (accept) begin
                word_q    <= d_i;
                pending_q <= ~cfg_q;
                if (nxt_any) tx_byte_o <= byte_sel;
            end else if (xfer) begin
                pending_q <= after_clr;
                // Hold the last byte once the word is exhausted.
                if (nxt_any) tx_byte_o <= byte_sel;
            end
        end
    end

endmodule
